// File: rtl/median_pkg.sv
// Shared types and width helpers for the median stream input controller.
package median_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, DROP_LINE} state_e;

  localparam int unsigned DEF_KERNEL_SIZE = 5;
  localparam int unsigned NUM_LINE_BUFS   = DEF_KERNEL_SIZE - 1;

  function automatic int unsigned col_width(input int unsigned img_width);
    return (img_width > 1) ? $clog2(img_width) : 1;
  endfunction

  function automatic int unsigned row_width(input int unsigned img_height);
    return (img_height > 1) ? $clog2(img_height) : 1;
  endfunction

  // Line-buffer select width, never narrower than one bit
  function automatic int unsigned sel_width(input int unsigned kernel_size);
    return (kernel_size - 1 > 1) ? $clog2(kernel_size - 1) : 1;
  endfunction

endpackage

// File: rtl/median_pos_counter.sv
// Column/row/line-buffer-select tracker with line-end, frame-end and resync controls.
module median_pos_counter
  import median_pkg::*;
#(
  parameter  int unsigned IMG_WIDTH   = 10,
  parameter  int unsigned IMG_HEIGHT  = 10,
  parameter  int unsigned KERNEL_SIZE = 5,
  localparam int unsigned COL_W       = col_width(IMG_WIDTH),
  localparam int unsigned ROW_W       = row_width(IMG_HEIGHT),
  localparam int unsigned SEL_W       = sel_width(KERNEL_SIZE)
) (
  input  logic             i_clk,
  input  logic             i_aresetn,
  input  logic             i_advance,
  input  logic             i_line_end,
  input  logic             i_frame_end,
  input  logic             i_resync,
  output logic [COL_W-1:0] o_col,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_last_col_c,
  output logic             o_last_pix_c
);

  logic [ROW_W-1:0] row;
  logic             last_row;
  logic [SEL_W-1:0] sel_next;

  always_comb begin
    o_last_col_c = (o_col == COL_W'(IMG_WIDTH - 1));
    last_row     = (row == ROW_W'(IMG_HEIGHT - 1));
    o_last_pix_c = o_last_col_c & last_row;
    sel_next     = (o_sel == SEL_W'(KERNEL_SIZE - 2)) ? '0 : o_sel + SEL_W'(1);
  end

  // Resync restarts at (0,0) already consumed, so the next column is 1
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      o_col <= '0;
      row   <= '0;
      o_sel <= '0;
    end else if (i_resync) begin
      o_col <= COL_W'(1);
      row   <= '0;
      o_sel <= '0;
    end else if (i_frame_end) begin
      o_col <= '0;
      row   <= '0;
    end else if (i_line_end) begin
      o_col <= '0;
      if (!last_row) row <= row + ROW_W'(1);
      o_sel <= sel_next;
    end else if (i_advance) begin
      o_col <= o_col + COL_W'(1);
    end
  end

endmodule

// File: rtl/median_stream_ctrl.sv
// AXI4-Stream input controller for the median datapath: framing, addressing, error resync.
// Optional statistics counters are built when MEDIAN_CTRL_STATS_EN is defined.
module median_stream_ctrl
  import median_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH  = 8,
  parameter  int unsigned IMG_WIDTH   = 10,
  parameter  int unsigned IMG_HEIGHT  = 10,
  parameter  int unsigned KERNEL_SIZE = 5,
  localparam int unsigned COL_W       = col_width(IMG_WIDTH),
  localparam int unsigned SEL_W       = sel_width(KERNEL_SIZE)
) (
  input  logic                  i_clk,
  input  logic                  i_aresetn,
  input  logic                  i_enable,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] o_pixel,
  output logic                  o_image_data_valid,
  output logic                  o_start_of_frame,
  output logic                  o_window_shift,
  output logic                  o_lb_wr_en,
  output logic [COL_W-1:0]      o_lb_wr_addr,
  output logic [SEL_W-1:0]      o_lb_wr_sel,
  output logic                  o_frame_done,
  output logic                  o_err_early_eol,
  output logic                  o_err_late_eol,
  output logic                  o_err_sof
`ifdef MEDIAN_CTRL_STATS_EN
  ,
  output logic [15:0]           o_frame_count,
  output logic [15:0]           o_err_count
`endif
);

  state_e           state;
  logic             accept;
  logic             deliver;
  logic             resync;
  logic             advance;
  logic             line_end;
  logic             frame_end;
  logic [COL_W-1:0] col;
  logic [SEL_W-1:0] sel;
  logic             last_col;
  logic             last_pix;

  // Counter controls decoded from the current state and the accepted beat
  always_comb begin
    accept    = s_axis_tvalid & s_axis_tready;
    resync    = 1'b0;
    advance   = 1'b0;
    line_end  = 1'b0;
    frame_end = 1'b0;
    deliver   = 1'b0;
    if (accept) begin
      case (state)
        WAIT_SOF:  resync = s_axis_tuser;
        DROP_LINE: resync = s_axis_tuser;
        ACTIVE: begin
          deliver = 1'b1;
          if (s_axis_tuser)               resync    = 1'b1;
          else if (last_pix)              frame_end = 1'b1;
          else if (last_col | s_axis_tlast) line_end = 1'b1;
          else                            advance   = 1'b1;
        end
        default: ;
      endcase
    end
    deliver = deliver | resync;
  end

  median_pos_counter #(
    .IMG_WIDTH   (IMG_WIDTH),
    .IMG_HEIGHT  (IMG_HEIGHT),
    .KERNEL_SIZE (KERNEL_SIZE)
  ) u_pos (
    .i_clk        (i_clk),
    .i_aresetn    (i_aresetn),
    .i_advance    (advance),
    .i_line_end   (line_end),
    .i_frame_end  (frame_end),
    .i_resync     (resync),
    .o_col        (col),
    .o_sel        (sel),
    .o_last_col_c (last_col),
    .o_last_pix_c (last_pix)
  );

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state              <= IDLE;
      s_axis_tready      <= 1'b0;
      o_pixel            <= '0;
      o_image_data_valid <= 1'b0;
      o_start_of_frame   <= 1'b0;
      o_window_shift     <= 1'b0;
      o_lb_wr_en         <= 1'b0;
      o_lb_wr_addr       <= '0;
      o_lb_wr_sel        <= '0;
      o_frame_done       <= 1'b0;
      o_err_early_eol    <= 1'b0;
      o_err_late_eol     <= 1'b0;
      o_err_sof          <= 1'b0;
    end else begin
      o_image_data_valid <= deliver;
      o_window_shift     <= deliver;
      o_lb_wr_en         <= deliver;
      o_start_of_frame   <= resync;
      o_err_sof          <= resync & (state != WAIT_SOF);
      o_frame_done       <= frame_end;
      o_err_early_eol    <= line_end & ~last_col;
      o_err_late_eol     <= (line_end | frame_end) & last_col & ~s_axis_tlast;
      if (deliver) begin
        o_pixel      <= s_axis_tdata;
        o_lb_wr_addr <= resync ? '0 : col;
        o_lb_wr_sel  <= resync ? '0 : sel;
      end
      case (state)
        IDLE: begin
          if (i_enable) begin
            state         <= WAIT_SOF;
            s_axis_tready <= 1'b1;
          end
        end
        WAIT_SOF: begin
          if (resync) state <= ACTIVE;
        end
        ACTIVE: begin
          if (frame_end) begin
            state         <= i_enable ? WAIT_SOF : IDLE;
            s_axis_tready <= i_enable;
          end else if (line_end & last_col & ~s_axis_tlast) begin
            state <= DROP_LINE;
          end
        end
        DROP_LINE: begin
          if (resync || (accept && s_axis_tlast)) state <= ACTIVE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEDIAN_CTRL_STATS_EN
  // Frame counter wraps; error counter saturates
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      o_frame_count <= '0;
      o_err_count   <= '0;
    end else begin
      if (o_frame_done) o_frame_count <= o_frame_count + 16'd1;
      if ((o_err_early_eol | o_err_late_eol | o_err_sof) && (o_err_count != 16'hFFFF))
        o_err_count <= o_err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_median_stream_ctrl.sv
// Directed self-checking bench for median_stream_ctrl (10x10 frame, 5x5 kernel).
module tb_median_stream_ctrl;

  logic       clk = 1'b0;
  logic       aresetn = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] tdata = '0;
  logic       tvalid = 1'b0;
  logic       tready;
  logic       tuser = 1'b0;
  logic       tlast = 1'b0;
  logic [7:0] pixel;
  logic       valid, sof, shift, wr_en, done, e_early, e_late, e_sof;
  logic [3:0] wr_addr;
  logic [1:0] wr_sel;
`ifdef MEDIAN_CTRL_STATS_EN
  logic [15:0] frame_count, err_count;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int n_valid = 0, n_sof = 0, n_early = 0, n_late = 0, n_serr = 0, n_done = 0;
  int b_valid, b_sof, b_early, b_late, b_serr, b_done;

  always #5 clk = ~clk;

  median_stream_ctrl #(
    .DATA_WIDTH(8), .IMG_WIDTH(10), .IMG_HEIGHT(10), .KERNEL_SIZE(5)
  ) dut (
    .i_clk              (clk),
    .i_aresetn          (aresetn),
    .i_enable           (enable),
    .s_axis_tdata       (tdata),
    .s_axis_tvalid      (tvalid),
    .s_axis_tready      (tready),
    .s_axis_tuser       (tuser),
    .s_axis_tlast       (tlast),
    .o_pixel            (pixel),
    .o_image_data_valid (valid),
    .o_start_of_frame   (sof),
    .o_window_shift     (shift),
    .o_lb_wr_en         (wr_en),
    .o_lb_wr_addr       (wr_addr),
    .o_lb_wr_sel        (wr_sel),
    .o_frame_done       (done),
    .o_err_early_eol    (e_early),
    .o_err_late_eol     (e_late),
    .o_err_sof          (e_sof)
`ifdef MEDIAN_CTRL_STATS_EN
    ,
    .o_frame_count      (frame_count),
    .o_err_count        (err_count)
`endif
  );

  // Pulse tallies, sampled mid-cycle
  always @(negedge clk) begin
    if (aresetn) begin
      n_valid <= n_valid + int'(valid);
      n_sof   <= n_sof + int'(sof);
      n_early <= n_early + int'(e_early);
      n_late  <= n_late + int'(e_late);
      n_serr  <= n_serr + int'(e_sof);
      n_done  <= n_done + int'(done);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic u, input logic l, input logic ev,
                      input int ea, input int es, input logic esof, input logic edone);
    tdata = d; tuser = u; tlast = l; tvalid = 1'b1;
    @(posedge clk);
    #1;
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
    chk("valid", valid, ev);
    if (ev) begin
      chk("pixel", pixel, d);
      chk("wr_addr", wr_addr, ea);
      chk("wr_sel", wr_sel, es);
      chk("sof", sof, esof);
      chk("shift", shift, 1'b1);
      chk("wr_en", wr_en, 1'b1);
      chk("frame_done", done, edone);
    end
  endtask

  task automatic send_cols(input int r, input int c0, input int c1, input logic last_on_end,
                           input logic sof_first, input logic done_on_end);
    for (int c = c0; c <= c1; c++) begin
      beat(8'(r * 16 + c), sof_first && (c == c0), last_on_end && (c == c1), 1'b1,
           c, r % 4, sof_first && (c == c0), done_on_end && (c == c1));
    end
  endtask

  task automatic rows(input int r0, input int r1);
    for (int r = r0; r <= r1; r++) send_cols(r, 0, 9, 1'b1, r == 0, r == 9);
  endtask

  task automatic snap();
    b_valid = n_valid; b_sof = n_sof; b_early = n_early;
    b_late = n_late; b_serr = n_serr; b_done = n_done;
  endtask

  task automatic counts(input int ev, input int es, input int ee, input int el,
                        input int ese, input int ed);
    idle(1);
    chk("n_valid", n_valid - b_valid, ev);
    chk("n_sof", n_sof - b_sof, es);
    chk("n_early", n_early - b_early, ee);
    chk("n_late", n_late - b_late, el);
    chk("n_serr", n_serr - b_serr, ese);
    chk("n_done", n_done - b_done, ed);
  endtask

  task automatic all_zero();
    chk("z_tready", tready, 0); chk("z_valid", valid, 0); chk("z_sof", sof, 0);
    chk("z_pixel", pixel, 0); chk("z_addr", wr_addr, 0); chk("z_sel", wr_sel, 0);
    chk("z_wr_en", wr_en, 0); chk("z_shift", shift, 0); chk("z_done", done, 0);
    chk("z_errs", {e_early, e_late, e_sof}, 0);
  endtask

  initial begin
    // Reset state and IDLE hold
    repeat (2) @(posedge clk);
    #1;
    all_zero();
    @(negedge clk) aresetn = 1'b1;
    idle(3);
    chk("idle_tready", tready, 0);
    enable = 1'b1;
    idle(1);
    chk("wait_sof_tready", tready, 1);

    // Nominal frame
    snap();
    rows(0, 9);
    chk("tready_after_frame", tready, 1);
    counts(100, 1, 0, 0, 0, 1);

    // Junk beats ahead of start of frame
    snap();
    for (int i = 0; i < 3; i++) beat(8'(200 + i), 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    rows(0, 9);
    counts(100, 1, 0, 0, 0, 1);

    // Early end of line at column 6 of line 2
    snap();
    rows(0, 1);
    send_cols(2, 0, 6, 1'b1, 1'b0, 1'b0);
    chk("early_pulse", e_early, 1);
    rows(3, 9);
    counts(97, 1, 1, 0, 0, 1);

    // Late end of line on line 1, then dropped beats
    snap();
    rows(0, 0);
    send_cols(1, 0, 9, 1'b0, 1'b0, 1'b0);
    chk("late_pulse", e_late, 1);
    for (int i = 0; i < 3; i++) beat(8'(220 + i), 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    beat(8'd230, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    rows(2, 9);
    counts(100, 1, 0, 1, 0, 1);

    // Mid-frame start of frame at row 5, column 3
    snap();
    rows(0, 4);
    send_cols(5, 0, 2, 1'b0, 1'b0, 1'b0);
    send_cols(0, 0, 0, 1'b0, 1'b1, 1'b0);
    chk("sof_err_pulse", e_sof, 1);
    chk("sof_with_err", sof, 1);
    send_cols(0, 1, 9, 1'b1, 1'b0, 1'b0);
    rows(1, 9);
    counts(153, 2, 0, 0, 1, 1);

    // Enable dropped mid-frame: frame completes then input stalls
    snap();
    rows(0, 3);
    enable = 1'b0;
    rows(4, 9);
    chk("tready_dropped", tready, 0);
    beat(8'd77, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    beat(8'd78, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("tready_still_low", tready, 0);
    counts(100, 1, 0, 0, 0, 1);

    // Reset in the middle of a line
    enable = 1'b1;
    idle(2);
    chk("reenable_tready", tready, 1);
    send_cols(0, 0, 3, 1'b0, 1'b1, 1'b0);
    tdata = 8'd99; tvalid = 1'b1;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    chk("pre_reset_valid", valid, 1);
    chk("pre_reset_addr", wr_addr, 4);
    aresetn = 1'b0;
    #1;
    all_zero();
    @(negedge clk) aresetn = 1'b1;
    idle(2);
    chk("post_reset_tready", tready, 1);
    snap();
    beat(8'd55, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    rows(0, 9);
    counts(100, 1, 0, 0, 0, 1);
`ifdef MEDIAN_CTRL_STATS_EN
    chk("frame_count", frame_count, 1);
    chk("err_count", err_count, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
